circ_smpl_queue: RTL and testbench

- Parametrised multi-channel circular sample queue that feeds the FIR filter sequencers in the audio path.
- Stores incoming audio samples per channel in inferred dual-port RAM.
- Once WIN_LEN samples are held, each accepted write replays the most recent WIN_LEN samples, oldest first, as a contiguous valid-qualified stream.
- Adds a decimating write mode, pending-window queuing, overrun detection and a synchronous clear.

---
 rtl/circ_smpl_queue_if.sv | 30 +++
 rtl/circ_smpl_queue.sv | 153 +++++++++++++++
 tb/tb_circ_smpl_queue.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/circ_smpl_queue_if.sv
// Purpose: bundles the sample write side and the window replay side of circ_smpl_queue.
// Latency: none, this file holds wiring only.
// Backpressure: none; the sink must take every smpl_vld beat.
// Ports: master drives clr/dec_en/wrt_smpl/smpl_in and observes the replay outputs;
//        slave is the queue itself.
interface circ_smpl_queue_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2
);
    logic                     clr;
    logic                     dec_en;
    logic                     wrt_smpl;
    logic [NUM_CH*DATA_W-1:0] smpl_in;
    logic [NUM_CH*DATA_W-1:0] smpl_out;
    logic                     smpl_vld;
    logic                     sequencing;
    logic                     seq_done;
    logic                     full;
    logic                     overrun;

    modport master (
        output clr, dec_en, wrt_smpl, smpl_in,
        input  smpl_out, smpl_vld, sequencing, seq_done, full, overrun
    );

    modport slave (
        input  clr, dec_en, wrt_smpl, smpl_in,
        output smpl_out, smpl_vld, sequencing, seq_done, full, overrun
    );
endinterface

// File: rtl/circ_smpl_queue.sv
// Purpose: multi-channel circular sample queue; once WIN_LEN samples are held, every accepted
//          write replays the newest WIN_LEN samples oldest-first for the FIR sequencers.
// Latency: first smpl_vld 2 cycles after the triggering wrt_smpl; seq_done 1 cycle after last valid.
// Backpressure: none; triggers arriving mid-replay queue one pending window, further ones set overrun.
// Ports: clk, rst_n (sync, active-low), q (slave side of circ_smpl_queue_if).
module circ_smpl_queue #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10,
    parameter int WIN_LEN = 1021,
    parameter int NUM_CH  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    circ_smpl_queue_if.slave   q
);
    localparam int                DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] WIN_A  = ADDR_W'(WIN_LEN);
    localparam logic [ADDR_W-1:0] WIN_M1 = ADDR_W'(WIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

    state_t            state, state_n;
    logic              srst;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, cnt, rd_cnt;
    logic [ADDR_W-1:0] start_ptr;
    logic              phase, pend, overrun, smpl_vld, seq_done;
    logic              accept, trig, rd_en, ld_start, sequencing;

    // clr behaves like reset for all control state; RAM contents are left alone.
    assign srst   = !rst_n || q.clr;
    assign accept = q.wrt_smpl && (!q.dec_en || phase);
    // cnt never exceeds WIN_LEN, so this is "post-write cnt reaches WIN_LEN".
    assign trig   = accept && (cnt >= WIN_M1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (srst) state <= IDLE;
        else      state <= state_n;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_n   = state;
        ld_start  = 1'b0;
        start_ptr = wr_ptr - WIN_A;        // newest window held right now
        case (state)
            IDLE: begin
                if (trig) begin
                    state_n   = READ;
                    ld_start  = 1'b1;
                    // Include the sample being written this cycle.
                    start_ptr = wr_ptr + ADDR_W'(1) - WIN_A;
                end else if (pend) begin
                    state_n  = READ;
                    ld_start = 1'b1;
                end
            end
            READ: begin
                if (rd_cnt == WIN_M1) state_n = DONE;
            end
            DONE: begin
                if (pend) begin
                    state_n  = READ;
                    ld_start = 1'b1;
                end else begin
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rd_en      = (state == READ);
        sequencing = (state != IDLE);
    end

    // ---------------- pointers, counters, flags ----------------
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            rd_cnt   <= '0;
            phase    <= 1'b0;
            pend     <= 1'b0;
            overrun  <= 1'b0;
            smpl_vld <= 1'b0;
            seq_done <= 1'b0;
        end else begin
            if (q.dec_en) begin
                if (q.wrt_smpl) phase <= !phase;
            end else begin
                phase <= 1'b0;
            end

            if (accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (cnt != WIN_A) cnt <= cnt + ADDR_W'(1);
            end

            if (ld_start) begin
                rd_ptr <= start_ptr;
                rd_cnt <= '0;
            end else if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                rd_cnt <= rd_cnt + ADDR_W'(1);
            end

            // IDLE consumes any pend (or starts straight from a trigger);
            // DONE consumes pend and captures a same-cycle trigger.
            case (state)
                IDLE: pend <= 1'b0;
                READ: begin
                    if (trig) begin
                        if (pend) overrun <= 1'b1;
                        else      pend    <= 1'b1;
                    end
                end
                DONE:    pend <= trig;
                default: pend <= 1'b0;
            endcase

            smpl_vld <= rd_en;
            seq_done <= (state == DONE);
        end
    end

    // ---------------- per-channel RAM ----------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (accept && !srst) mem[wr_ptr] <= q.smpl_in[c*DATA_W +: DATA_W];
        end

        // Output register holds its value between windows.
        always_ff @(posedge clk) begin
            if (srst)       rd_q <= '0;
            else if (rd_en) rd_q <= mem[rd_ptr];
        end

        assign q.smpl_out[c*DATA_W +: DATA_W] = rd_q;
    end

    assign q.smpl_vld   = smpl_vld;
    assign q.sequencing = sequencing;
    assign q.seq_done   = seq_done;
    assign q.full       = (cnt == WIN_A);
    assign q.overrun    = overrun;
endmodule

// File: tb/tb_circ_smpl_queue.sv
module tb_circ_smpl_queue;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int WIN_LEN = 5;
    localparam int NUM_CH  = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    circ_smpl_queue_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

    circ_smpl_queue #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIN_LEN(WIN_LEN), .NUM_CH(NUM_CH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;
    int exp_done = 0;
    int n_done = 0;
    logic [31:0] exp_q[$];
    int          exp_len_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int v);
        return {16'(v + 100), 16'(v)};
    endfunction

    task automatic push_one(input int v);
        exp_q.push_back(pack(v));
    endtask

    // Full window of consecutive values ending at newest.
    task automatic push_win(input int newest);
        for (int k = newest - WIN_LEN + 1; k <= newest; k++) push_one(k);
        exp_len_q.push_back(WIN_LEN);
        exp_done++;
    endtask

    // Every call is entered 1 time unit after a rising edge and leaves the same way.
    task automatic wr(input int v);
        bus.wrt_smpl = 1'b1;
        bus.smpl_in  = pack(v);
        @(posedge clk); #1;
        bus.wrt_smpl = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!bus.sequencing && !bus.smpl_vld && !bus.seq_done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_idle_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    // ---------------- monitor ----------------
    int run_len = 0;
    bit prev_vld = 1'b0;
    always @(negedge clk) begin
        if (bus.smpl_vld === 1'b1) begin
            run_len++;
            if (exp_q.size() == 0) chk("unexpected_vld", bus.smpl_out, 32'hFFFF_FFFF);
            else                   chk("smpl_out", bus.smpl_out, exp_q.pop_front());
        end else if (prev_vld) begin
            if (exp_len_q.size() == 0) chk("unexpected_run", run_len, 0);
            else                       chk("run_len", run_len, exp_len_q.pop_front());
            run_len = 0;
        end
        if (bus.seq_done === 1'b1) begin
            n_done++;
            chk("seq_done_pos", {30'd0, prev_vld, bus.smpl_vld}, 32'd2);
        end
        prev_vld = (bus.smpl_vld === 1'b1);
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        bus.clr      = 1'b0;
        bus.dec_en   = 1'b0;
        bus.wrt_smpl = 1'b0;
        bus.smpl_in  = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_full", bus.full, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_seq", bus.sequencing, 0);
        chk("rst_vld", bus.smpl_vld, 0);
        chk("rst_out", bus.smpl_out, 0);

        // Fill 1..5, first replay.
        for (int v = 1; v <= 4; v++) wr(v);
        chk("t1_not_full", bus.full, 0);
        chk("t1_no_seq", bus.sequencing, 0);
        push_win(5);
        wr(5);
        chk("t1_full", bus.full, 1);
        chk("t1_seq_first_read", bus.sequencing, 1);
        chk("t1_vld_latency", bus.smpl_vld, 0);
        @(posedge clk); #1;
        chk("t1_vld_2cyc", bus.smpl_vld, 1);
        wait_idle("t1");
        chk("t1_hold_out", bus.smpl_out, pack(5));

        // Spaced writes 6..12, pointer wraps at 8.
        for (int v = 6; v <= 12; v++) begin
            push_win(v);
            wr(v);
            repeat (9) @(posedge clk);
            #1;
        end
        wait_idle("t2");

        // Decimating mode: only even strobes stored.
        bus.clr = 1'b1; @(posedge clk); #1; bus.clr = 1'b0;
        chk("t3_clr_full", bus.full, 0);
        bus.dec_en = 1'b1;
        for (int v = 1; v <= 9; v++) wr(v);
        chk("t3_not_full", bus.full, 0);
        push_one(2); push_one(4); push_one(6); push_one(8); push_one(10);
        exp_len_q.push_back(WIN_LEN);
        exp_done++;
        wr(10);
        chk("t3_full", bus.full, 1);
        bus.dec_en = 1'b0;
        wait_idle("t3");

        // Pending window and overrun.
        bus.clr = 1'b1; @(posedge clk); #1; bus.clr = 1'b0;
        for (int v = 21; v <= 24; v++) wr(v);
        push_win(25);
        push_win(27);
        wr(25);
        wr(26);
        chk("t4_no_overrun_yet", bus.overrun, 0);
        wr(27);
        chk("t4_overrun", bus.overrun, 1);
        wait_idle("t4");
        chk("t4_overrun_sticky", bus.overrun, 1);

        // clr mid-READ: window 24,25,26,27,31 aborted after two beats.
        push_one(24); push_one(25);
        exp_len_q.push_back(2);
        wr(31);
        repeat (2) @(posedge clk);
        #1 bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        chk("t5_vld", bus.smpl_vld, 0);
        chk("t5_seq", bus.sequencing, 0);
        chk("t5_full", bus.full, 0);
        chk("t5_overrun", bus.overrun, 0);
        chk("t5_out", bus.smpl_out, 0);
        for (int v = 41; v <= 44; v++) wr(v);
        chk("t5_refill_not_full", bus.full, 0);
        chk("t5_refill_no_seq", bus.sequencing, 0);
        push_win(45);
        wr(45);
        wait_idle("t5");

        // Reset while writing, mid-replay of 42..46 after one beat.
        push_one(42);
        exp_len_q.push_back(1);
        wr(46);
        @(posedge clk); #1;
        rst_n        = 1'b0;
        bus.wrt_smpl = 1'b1;
        bus.smpl_in  = pack(50);
        @(posedge clk); #1;
        rst_n        = 1'b1;
        bus.wrt_smpl = 1'b0;
        chk("t6_full", bus.full, 0);
        chk("t6_seq", bus.sequencing, 0);
        chk("t6_vld", bus.smpl_vld, 0);
        chk("t6_done", bus.seq_done, 0);
        chk("t6_out", bus.smpl_out, 0);
        for (int v = 51; v <= 54; v++) wr(v);
        chk("t6_not_stored", bus.full, 0);
        chk("t6_no_seq", bus.sequencing, 0);
        push_win(55);
        wr(55);
        wait_idle("t6");

        repeat (3) @(posedge clk);
        #1;
        chk("end_exp_q_empty", exp_q.size(), 0);
        chk("end_len_q_empty", exp_len_q.size(), 0);
        chk("seq_done_count", n_done, exp_done);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
